// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue/writeback controller for the two-stage 32x32 multiplier
//
// Purpose: accepts MUL.W / MULH.W / MULH.WU micro-ops and drives the multiplier
// operands. It tracks each op through the multiplier's pipeline register and
// selects the low or high product word. Results are buffered in a DEPTH-entry
// FIFO, so writeback backpressure never drops a product.
//
// Ports:
//   clock, reset        clock; synchronous active-low reset
//   flush               kill every in-flight and buffered op this cycle
//   in_valid/in_ready   micro-op handshake from EX
//   in_op               00 MUL.W, 01 MULH.W, 10 MULH.WU, 11 treated as MUL.W
//   in_src1, in_src2    operands
//   in_rd               destination tag, passed through unchanged
//   mul_signed/x/y      operands to the multiplier (zero when nothing is issued)
//   mul_result          64-bit product, valid one cycle after its operands
//   out_valid/out_ready result handshake to writeback
//   out_data, out_rd    selected result word and tag of the FIFO head
module mul_issue_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [4:0]  in_rd,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] lastPtr = PW'(DEPTH - 1);
  localparam logic [CW:0]   depthW  = (CW + 1)'(DEPTH);

  localparam logic [1:0] OP_MULH_W  = 2'b01;
  localparam logic [1:0] OP_MULH_WU = 2'b10;

  // Multiplier pipeline stage tracking.
  logic        s1Valid;
  logic [1:0]  s1Op;
  logic [4:0]  s1Rd;

  // Result FIFO.
  logic [31:0]   dataMem [DEPTH];
  logic [4:0]    rdMem   [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;

  logic          live;
  logic          accept;
  logic          push;
  logic          pop;
  logic          notEmpty;
  logic [CW:0]   pending;
  logic [31:0]   selWord;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == lastPtr) ? '0 : p + PW'(1);
  endfunction

  assign live     = reset && !flush;
  assign notEmpty = (count != '0);
  assign out_valid = live && notEmpty;
  assign pop       = out_valid && out_ready;

  // Everything already committed to a FIFO slot once this cycle ends:
  // buffered entries plus the op in the multiplier, less the one leaving now.
  // Keeping this below DEPTH means a push can never find the FIFO full.
  // Invariant count + s1Valid <= DEPTH, and pop implies count >= 1, so no underflow.
  assign pending  = {1'b0, count} + (CW + 1)'(s1Valid) - (CW + 1)'(pop);
  assign in_ready = live && (pending < depthW);
  assign accept   = in_valid && in_ready;

  assign mul_signed = accept && (in_op != OP_MULH_WU);
  assign mul_x      = accept ? in_src1 : '0;
  assign mul_y      = accept ? in_src2 : '0;

  assign push    = s1Valid && live;
  assign selWord = ((s1Op == OP_MULH_W) || (s1Op == OP_MULH_WU)) ? mul_result[63:32]
                                                                 : mul_result[31:0];

  assign out_data = (reset && notEmpty) ? dataMem[rdPtr] : '0;
  assign out_rd   = (reset && notEmpty) ? rdMem[rdPtr]   : '0;

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      s1Valid <= 1'b0;
      s1Op    <= '0;
      s1Rd    <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
    end else begin
      s1Valid <= accept;
      s1Op    <= accept ? in_op : '0;
      s1Rd    <= accept ? in_rd : '0;
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (push) begin
      dataMem[wrPtr] <= selWord;
      rdMem[wrPtr]   <= s1Rd;
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - directed self-checking bench for mul_issue_ctrl
module tb_mul_issue_ctrl;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_rd;
  logic        mul_signed;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  int tests = 0;
  int fails = 0;

  mul_issue_ctrl #(.DEPTH(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y),
    .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural one-cycle multiplier: sign-extended operands multiplied mod 2^64.
  logic [63:0] xExt, yExt;
  always_comb begin
    xExt = mul_signed ? {{32{mul_x[31]}}, mul_x} : {32'b0, mul_x};
    yExt = mul_signed ? {{32{mul_y[31]}}, mul_y} : {32'b0, mul_y};
  end
  always_ff @(posedge clock) mul_result <= xExt * yExt;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    in_valid = v; in_op = op; in_src1 = a; in_src2 = b; in_rd = rd;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick(); tick();
    settle();
    tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 32'h0)  begin fails++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    tests++; if (out_rd !== 5'd0)     begin fails++; $display("FAIL rst_out_rd got %0d exp 0", out_rd); end
    tick();
    reset = 1'b1;
    settle();
    tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL rst_release_valid got %b exp 0", out_valid); end
    tick();
  endtask

  task automatic test_sign_modes();
    logic [1:0]  ops  [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] exps [3] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(i + 1));
      settle();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL sign%0d_in_ready got %b exp 1", i, in_ready); end
      tests++; if (mul_signed !== (ops[i] != 2'b10)) begin fails++; $display("FAIL sign%0d_mul_signed got %b", i, mul_signed); end
      tests++; if (mul_x !== 32'hFFFFFFFF) begin fails++; $display("FAIL sign%0d_mul_x got %h exp ffffffff", i, mul_x); end
      tick();
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      settle();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sign%0d_t1_valid got %b exp 0", i, out_valid); end
      tick();
      settle();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sign%0d_t2_valid got %b exp 1", i, out_valid); end
      tests++; if (out_data !== exps[i]) begin fails++; $display("FAIL sign%0d_data got %h exp %h", i, out_data, exps[i]); end
      tests++; if (out_rd !== 5'(i + 1)) begin fails++; $display("FAIL sign%0d_rd got %0d exp %0d", i, out_rd, i + 1); end
      tick();
    end
  endtask

  task automatic test_edge_operands();
    logic [1:0]  ops [5] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b11};
    logic [31:0] as  [5] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd3};
    logic [31:0] bs  [5] = '{32'h80000000, 32'h80000000, 32'h00000002, 32'h00000002, 32'd5};
    logic [31:0] exs [5] = '{32'h40000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h0000000F};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 5'(16 + i));
      tick();
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      tick();
      settle();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL edge%0d_valid got %b exp 1", i, out_valid); end
      tests++; if (out_data !== exs[i]) begin fails++; $display("FAIL edge%0d_data got %h exp %h", i, out_data, exs[i]); end
      tests++; if (out_rd !== 5'(16 + i)) begin fails++; $display("FAIL edge%0d_rd got %0d exp %0d", i, out_rd, 16 + i); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) drive(1'b1, 2'b00, 32'(cyc + 1), 32'd3, 5'(cyc + 1));
      else         drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      settle();
      if (cyc < 8) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready c%0d got %b exp 1", cyc, in_ready); end
      end
      if (cyc >= 2 && cyc <= 9) begin
        tests++;
        if (out_valid !== 1'b1 || out_rd !== 5'(cyc - 1) || out_data !== 32'(3 * (cyc - 1))) begin
          fails++;
          $display("FAIL b2b_out c%0d got v=%b rd=%0d d=%h exp v=1 rd=%0d d=%h",
                   cyc, out_valid, out_rd, out_data, cyc - 1, 32'(3 * (cyc - 1)));
        end
      end else begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle c%0d got %b exp 0", cyc, out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'd2, 32'd3, 5'd10);
    settle();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_acc_a got %b exp 1", in_ready); end
    tick();
    drive(1'b1, 2'b00, 32'd4, 32'd5, 5'd11);
    settle();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_acc_b got %b exp 1", in_ready); end
    tick();
    drive(1'b1, 2'b00, 32'd6, 32'd7, 5'd12);
    settle();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd10) begin fails++; $display("FAIL bp_head got v=%b rd=%0d exp v=1 rd=10", out_valid, out_rd); end
    tick();
    settle();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_ready got %b exp 0", in_ready); end
    tick();
    out_ready = 1'b1;
    settle();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_reassert got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd10 || out_data !== 32'd6) begin
      fails++; $display("FAIL bp_drain_a got v=%b rd=%0d d=%h exp v=1 rd=10 d=6", out_valid, out_rd, out_data); end
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    settle();
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd11 || out_data !== 32'd20) begin
      fails++; $display("FAIL bp_drain_b got v=%b rd=%0d d=%h exp v=1 rd=11 d=14", out_valid, out_rd, out_data); end
    tick();
    settle();
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd12 || out_data !== 32'd42) begin
      fails++; $display("FAIL bp_drain_c got v=%b rd=%0d d=%h exp v=1 rd=12 d=2a", out_valid, out_rd, out_data); end
    tick();
    settle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", out_valid); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'd1, 32'd1, 5'd20);
    tick();
    drive(1'b1, 2'b00, 32'd2, 32'd2, 5'd21);
    settle();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fl_acc_b got %b exp 1", in_ready); end
    tick();
    flush = 1'b1;
    drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd23);
    settle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_valid got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL fl_ready got %b exp 0", in_ready); end
    tests++; if (mul_x !== 32'h0)    begin fails++; $display("FAIL fl_mul_x got %h exp 0", mul_x); end
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'd7, 32'd8, 5'd22);
    settle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_after_valid got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL fl_after_ready got %b exp 1", in_ready); end
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    settle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_no_stale got %b exp 0", out_valid); end
    tick();
    settle();
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd22 || out_data !== 32'd56) begin
      fails++; $display("FAIL fl_new_op got v=%b rd=%0d d=%h exp v=1 rd=22 d=38", out_valid, out_rd, out_data); end
    tick();
    settle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_end got %b exp 0", out_valid); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd30);
    tick();
    reset = 1'b0;
    drive(1'b1, 2'b01, 32'hFFFFFFFF, 32'h12345678, 5'd31);
    settle();
    tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL rmo_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL rmo_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 32'h0 || out_rd !== 5'd0) begin fails++; $display("FAIL rmo_out got d=%h rd=%0d exp 0", out_data, out_rd); end
    tests++; if (mul_x !== 32'h0 || mul_y !== 32'h0 || mul_signed !== 1'b0) begin
      fails++; $display("FAIL rmo_mul got x=%h y=%h s=%b exp 0", mul_x, mul_y, mul_signed); end
    tick();
    reset = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    settle();
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL rmo_release_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmo_release_valid got %b exp 0", out_valid); end
    tick();
    settle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmo_stale1 got %b exp 0", out_valid); end
    tick();
    settle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmo_stale2 got %b exp 0", out_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sign_modes();
    test_edge_operands();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Issue and writeback controller for the two-stage Booth/Wallace 32×32 multiplier in the execute unit. It accepts LoongArch multiply micro-ops (MUL.W, MULH.W, MULH.WU) from the EX stage with a valid/ready handshake and drives the multiplier operands and signedness. It tracks the in-flight operation through the multiplier's pipeline register, selects the low or high result word, and buffers results in a small FIFO so that writeback backpressure never loses a product. It supports pipeline flush for branch mispredict and exceptions.

## Interface
- DEPTH, 2, result FIFO entries; legal values are ≥2.
- clock  in  1  single clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- flush  in  1  kill all in-flight and buffered ops this cycle.
- in_valid  in  1  micro-op present.
- in_ready  out  1  controller accepts the micro-op this cycle.
- in_op  in  2  00 MUL.W, 01 MULH.W, 10 MULH.WU, 11 reserved (executed as MUL.W).
- in_src1, in_src2  in  32  operands.
- in_rd  in  5  destination tag, carried to the output unchanged.
- mul_signed  out  1  to multiplier.
- mul_x, mul_y  out  32  to multiplier.
- mul_result  in  64  multiplier product; valid one cycle after its operands are presented.
- out_valid  out  1  result at FIFO head.
- out_ready  in  1  writeback accepts.
- out_data  out  32  selected result word.
- out_rd  out  5  tag of the head entry.

## Operation
- Accept: an op is accepted when in_valid && in_ready.
- Operand drive on accept: mul_x = in_src1, mul_y = in_src2, mul_signed = (in_op != 10).
- Operand drive otherwise: all operand outputs are 0.
- Stage register s1 holds {valid, op, rd}.
  - s1 loads the accepted op. It clears when nothing is accepted, on flush, and on reset.
- Result select while s1.valid is set:
  - op 00/11 → mul_result[31:0].
  - op 01/10 → mul_result[63:32].
- The selected word is pushed with s1.rd at the end of that cycle. mul_result is ignored when s1.valid = 0.
- FIFO: circular buffer, DEPTH entries, read/write pointers wrap modulo DEPTH, occupancy count 0..DEPTH.
  - out_valid = (count != 0) && !flush.
  - out_data and out_rd come from the head entry, or 0 when count = 0.
  - Pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- Ready: in_ready = reset && !flush && (count + s1.valid − pop) < DEPTH.
  - This is a combinational path from out_ready to in_ready.
  - The rule guarantees a push never finds the FIFO full.
- Flush: count ← 0, pointers ← 0, s1.valid ← 0. In the flush cycle no accept and no pop occur.
- Reset (reset = 0): same state as flush. Outputs during reset: in_ready 0, out_valid 0, out_data 0, out_rd 0, mul_* 0.
- Reset or flush mid-operation discards the result without generating any output.
- Tags are never reordered; results leave in acceptance order.

## Timing
- Latency:
  - Op accepted in cycle T; its result is selected in T+1.
  - out_valid is asserted in T+2, the earliest possible.
- Throughput: with DEPTH = 2 and out_ready held at 1, the controller sustains one op per cycle.
- Stall: with out_ready = 0, in_ready falls once count + s1.valid = DEPTH. At most DEPTH results are outstanding.
- After reset is released, in_ready = 1 in the first cycle with reset = 1.

## Test plan
- Sign modes, src1 = src2 = 0xFFFFFFFF:
  - MUL.W → 0x00000001.
  - MULH.W → 0x00000000.
  - MULH.WU → 0xFFFFFFFE.
  - Each result appears at T+2 with its rd.
- Edge operands:
  - 0x80000000 × 0x80000000: MULH.W → 0x40000000, MUL.W → 0x00000000.
  - 0x7FFFFFFF × 0x00000002: MULH.W → 0x00000000, MUL.W → 0xFFFFFFFE.
  - op 11 with 3 × 5 → 0x0000000F.
- Back-to-back: 8 ops (rd 1..8) on consecutive cycles with out_ready = 1.
  - in_ready stays 1 throughout.
  - Outputs arrive on 8 consecutive cycles starting at T+2, in rd order.
- Backpressure: out_ready = 0 while ops stream in.
  - Exactly DEPTH ops are accepted; in_ready then drops.
  - Raising out_ready drains them in order. in_ready reasserts in the same cycle as the first pop.
- Flush: flush is asserted while one op is in s1 and one is in the FIFO.
  - In the flush cycle: out_valid = 0, in_ready = 0.
  - Next cycle: count = 0, neither result is ever output, and a new op completes normally.
- Reset mid-op: reset = 0 in the cycle after an accept.
  - All outputs read 0 during reset.
  - After release, no stale result appears and in_ready = 1.
